cmos_capture_ctrl: RTL
======================

CMOS_CAPTURE_CTRL -- requirements
Module: cmos_capture_ctrl

Interface
REQ-001 Parameters SHALL be: C_DATA_WIDTH, 8, pixel width; C_IMG_WBITS, 12, width-counter bits; C_IMG_HBITS, 12, height-counter bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; all state is clocked on the rising edge of cmos_pclk.
REQ-003 Ports SHALL be:
- cmos_pclk  in  1  pixel clock.
- cmos_rst  in  1  synchronous active-high reset.
- cmos_vsync  in  1  high = vertical blanking.
- cmos_href  in  1  high = valid line pixel.
- cmos_data  in  C_DATA_WIDTH  pixel.
- cfg_width  in  C_IMG_WBITS  pixels per line, 1..max.
- cfg_height  in  C_IMG_HBITS  lines per frame, 1..max.
- cfg_continuous  in  1  1 = free-run, 0 = single-shot.
- ctl_start  in  1  start pulse.
- ctl_stop  in  1  stop request.
- m_axis_tready  in  1  sink ready; informational only, no stall.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tdata  out  C_DATA_WIDTH  pixel.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- sts_busy  out  1  FSM not in IDLE.
- sts_frame_done  out  1  one-cycle pulse per completed frame.
- sts_size_err  out  1  one-cycle pulse on geometry mismatch.
- sts_overflow  out  1  sticky; tvalid while tready low.
- sts_frame_cnt  out  16  completed frames.
- sts_err_cnt  out  16  size errors.

Function
REQ-004 vsync, href and data SHALL be registered once (stage S1); edges SHALL be detected between S1 and its one-cycle-delayed copy.
REQ-005 The FSM SHALL have states IDLE, SYNC, ARMED and CAPTURE.
REQ-006 FSM transitions:
- IDLE->SYNC on ctl_start.
- SYNC->ARMED when S1 vsync = 1, so mid-frame starts wait for blanking.
- ARMED->CAPTURE on S1 vsync falling edge.
- CAPTURE->ARMED on vsync rising edge if cfg_continuous = 1 and no stop is pending; otherwise CAPTURE->IDLE.
REQ-007 ctl_stop in SYNC or ARMED SHALL return the FSM to IDLE next cycle; in CAPTURE it SHALL set a stop-pending flag so the current frame completes.
REQ-008 ctl_start outside IDLE SHALL be ignored; simultaneous ctl_start and ctl_stop in IDLE SHALL be ignored.
REQ-009 cfg_width, cfg_height and cfg_continuous SHALL be sampled on ARMED->CAPTURE and held for the frame.
REQ-010 In CAPTURE, each S1 pixel with href = 1 and x < width SHALL produce m_axis_tvalid = 1 exactly 2 cycles after it appears on cmos_data.
REQ-011 Pixels with x >= width SHALL be dropped, and sts_size_err SHALL pulse once for that line.
REQ-012 x SHALL reset to 0 on each href falling edge; y SHALL increment on each href falling edge and reset to 0 on ARMED->CAPTURE.
REQ-013 m_axis_tuser SHALL assert on the pixel with x = 0 and y = 0.
REQ-014 m_axis_tlast SHALL assert on the pixel with x = width-1.
REQ-015 Lines with y >= height SHALL be dropped entirely.
REQ-016 An href falling edge with 0 < x < width SHALL pulse sts_size_err.
REQ-017 At frame end (vsync rising), y != height SHALL pulse sts_size_err.
REQ-018 sts_frame_done SHALL pulse at every frame end, including frames with errors.
REQ-019 Any size_err sources in the same cycle SHALL give one pulse and one err_cnt increment.
REQ-020 Counters SHALL saturate at their maximum value and SHALL never wrap.
REQ-021 sts_overflow SHALL set when tvalid = 1 and tready = 0, and clear only on reset.

Reset
REQ-022 On reset: FSM = IDLE, stop flag = 0, x = y = 0, all outputs = 0, and S1 registers = 0.
REQ-023 Reset mid-CAPTURE SHALL drop the frame with no tlast or frame_done emitted; reset has priority over all other inputs.

Configuration
REQ-024 With CMOS_CAPTURE_STATS_EN defined, sts_frame_cnt and sts_err_cnt SHALL be implemented as 16-bit saturating counters.
REQ-025 Without CMOS_CAPTURE_STATS_EN, sts_frame_cnt and sts_err_cnt SHALL be constant 0 with no counter registers; all other behaviour SHALL be unchanged.

Structure
REQ-026 Package cmos_capture_pkg SHALL hold the FSM state enum, the counter-width constant (16) and the default width/height constants.
REQ-027 A single sub-module cmos_edge_det SHALL provide S1 registration plus rise/fall pulses for vsync and href.

Verification
REQ-028 Single-shot 4x3 frame, start in IDLE -> 12 beats, tuser on beat 0, tlast on beats 3/7/11, one frame_done, no size_err, FSM returns to IDLE.
REQ-029 Start mid-frame (vsync = 0, href active) -> no output until the next vsync low period; then one full 4x3 frame.
REQ-030 Continuous mode, 3 frames, ctl_stop during frame 2 -> frames 1 and 2 complete, frame 3 not captured, frame_cnt = 2.
REQ-031 cfg 4x3 with sensor lines of 5 and of 2 pixels -> extra pixel dropped; one size_err per bad line; 2-pixel line has no tlast; err_cnt counts correctly.
REQ-032 tready held 0 during one beat -> sts_overflow = 1 and stays set until reset; data stream unchanged.
REQ-033 Reset asserted at pixel 5 of a 4x3 frame -> all outputs 0 next cycle, FSM = IDLE, no frame_done.

Source files
------------

// File: rtl/cmos_capture_pkg.sv
// Shared types and constants for the CMOS capture controller.
package cmos_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_ARMED   = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam int CNT_W      = 16;
   localparam int DEF_WIDTH  = 640;
   localparam int DEF_HEIGHT = 480;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cmos_edge_det.sv
// Input stage S1 for the sensor bus plus rise/fall pulses on vsync and href.
// Pulses compare S1 with its one-cycle-delayed copy.
module cmos_edge_det #(
   parameter int C_DATA_WIDTH = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    vsync_i,
   input  logic                    href_i,
   input  logic [C_DATA_WIDTH-1:0] data_i,
   output logic                    vsync_o,
   output logic                    href_o,
   output logic [C_DATA_WIDTH-1:0] data_o,
   output logic                    vsync_rise_o,
   output logic                    vsync_fall_o,
   output logic                    href_rise_o,
   output logic                    href_fall_o
);

   logic                    vsync_q, href_q, vsync_dly_q, href_dly_q;
   logic [C_DATA_WIDTH-1:0] data_q;

   // Register the sensor bus once and keep a delayed copy of the strobes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= '0;
         vsync_dly_q <= 1'b0;
         href_dly_q  <= 1'b0;
      end else begin
         vsync_q     <= vsync_i;
         href_q      <= href_i;
         data_q      <= data_i;
         vsync_dly_q <= vsync_q;
         href_dly_q  <= href_q;
      end
   end

   assign vsync_o      = vsync_q;
   assign href_o       = href_q;
   assign data_o       = data_q;
   assign vsync_rise_o = vsync_q & ~vsync_dly_q;
   assign vsync_fall_o = ~vsync_q & vsync_dly_q;
   assign href_rise_o  = href_q & ~href_dly_q;
   assign href_fall_o  = ~href_q & href_dly_q;

endmodule

// File: rtl/cmos_capture_ctrl.sv
// CMOS DVP frame capture controller: syncs to vsync, crops to the configured
// geometry and emits an AXI-Stream-like pixel stream with status pulses.
// Define CMOS_CAPTURE_STATS_EN to build the 16-bit frame/error counters;
// otherwise sts_frame_cnt/sts_err_cnt are tied to zero.
module cmos_capture_ctrl
   import cmos_capture_pkg::*;
#(
   parameter int C_DATA_WIDTH = 8,
   parameter int C_IMG_WBITS  = 12,
   parameter int C_IMG_HBITS  = 12
) (
   input  logic                    cmos_pclk,
   input  logic                    cmos_rst,
   input  logic                    cmos_vsync,
   input  logic                    cmos_href,
   input  logic [C_DATA_WIDTH-1:0] cmos_data,
   input  logic [C_IMG_WBITS-1:0]  cfg_width,
   input  logic [C_IMG_HBITS-1:0]  cfg_height,
   input  logic                    cfg_continuous,
   input  logic                    ctl_start,
   input  logic                    ctl_stop,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tvalid,
   output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic                    sts_busy,
   output logic                    sts_frame_done,
   output logic                    sts_size_err,
   output logic                    sts_overflow,
   output logic [CNT_W-1:0]        sts_frame_cnt,
   output logic [CNT_W-1:0]        sts_err_cnt
);

   localparam logic [C_IMG_WBITS-1:0] X_ONE = {{(C_IMG_WBITS-1){1'b0}}, 1'b1};
   localparam logic [C_IMG_HBITS-1:0] Y_ONE = {{(C_IMG_HBITS-1){1'b0}}, 1'b1};

   logic                    vsync_s1, href_s1;
   logic                    vsync_rise, vsync_fall, href_rise, href_fall;
   logic [C_DATA_WIDTH-1:0] data_s1;

   state_t                  state_q, state_d;
   logic                    stop_q, stop_d, cap_start;
   logic [C_IMG_WBITS-1:0]  x_q, x_cur, x_inc, width_q;
   logic [C_IMG_HBITS-1:0]  y_q, y_inc, y_end, height_q;
   logic                    cont_q;
   logic                    in_cap, pix_keep, frame_end;
   logic                    err_long, err_short, err_frame, size_err_d;
   logic                    tvalid_q, tuser_q, tlast_q;
   logic                    frame_done_q, size_err_q, overflow_q;
   logic [C_DATA_WIDTH-1:0] tdata_q;

   cmos_edge_det #(.C_DATA_WIDTH(C_DATA_WIDTH)) u_edge (
      .clk_i        (cmos_pclk),
      .rst_i        (cmos_rst),
      .vsync_i      (cmos_vsync),
      .href_i       (cmos_href),
      .data_i       (cmos_data),
      .vsync_o      (vsync_s1),
      .href_o       (href_s1),
      .data_o       (data_s1),
      .vsync_rise_o (vsync_rise),
      .vsync_fall_o (vsync_fall),
      .href_rise_o  (href_rise),
      .href_fall_o  (href_fall)
   );

   // x restarts at a line start even if a falling edge was never seen.
   assign in_cap     = (state_q == ST_CAPTURE);
   assign x_cur      = href_rise ? '0 : x_q;
   assign x_inc      = (&x_cur) ? x_cur : x_cur + X_ONE;
   assign y_inc      = (&y_q) ? y_q : y_q + Y_ONE;
   assign y_end      = href_fall ? y_inc : y_q;
   assign pix_keep   = in_cap && href_s1 && (x_cur < width_q) && (y_q < height_q);
   assign err_long   = in_cap && href_s1 && (x_cur == width_q);
   assign err_short  = in_cap && href_fall && (x_q != '0) && (x_q < width_q);
   assign frame_end  = in_cap && vsync_rise;
   assign err_frame  = frame_end && (y_end != height_q);
   assign size_err_d = err_long | err_short | err_frame;

   // Next-state logic; stop during CAPTURE is deferred to the frame end.
   always_comb begin
      state_d   = state_q;
      stop_d    = stop_q;
      cap_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            if (ctl_start && !ctl_stop) state_d = ST_SYNC;
         end
         ST_SYNC: begin
            if (ctl_stop)      state_d = ST_IDLE;
            else if (vsync_s1) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (ctl_stop) state_d = ST_IDLE;
            else if (vsync_fall) begin
               state_d   = ST_CAPTURE;
               cap_start = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (ctl_stop) stop_d = 1'b1;
            if (vsync_rise) begin
               stop_d  = 1'b0;
               state_d = (cont_q && !stop_q && !ctl_stop) ? ST_ARMED : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and stop-pending flag.
   always_ff @(posedge cmos_pclk) begin
      if (cmos_rst) begin
         state_q <= ST_IDLE;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
      end
   end

   // Pixel and line position within the frame being captured.
   always_ff @(posedge cmos_pclk) begin
      if (cmos_rst) begin
         x_q <= '0;
         y_q <= '0;
      end else if (cap_start) begin
         x_q <= '0;
         y_q <= '0;
      end else if (in_cap) begin
         if (href_fall) begin
            x_q <= '0;
            y_q <= y_inc;
         end else if (href_s1) begin
            x_q <= x_inc;
         end
      end
   end

   // Geometry and mode are frozen for the whole frame at capture start.
   always_ff @(posedge cmos_pclk) begin
      if (cap_start) begin
         width_q  <= cfg_width;
         height_q <= cfg_height;
         cont_q   <= cfg_continuous;
      end
   end

   // Output stage: pixel stream and status pulses, one cycle after S1.
   always_ff @(posedge cmos_pclk) begin
      if (cmos_rst) begin
         tvalid_q     <= 1'b0;
         tdata_q      <= '0;
         tuser_q      <= 1'b0;
         tlast_q      <= 1'b0;
         frame_done_q <= 1'b0;
         size_err_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         tvalid_q     <= pix_keep;
         if (pix_keep) tdata_q <= data_s1;
         tuser_q      <= pix_keep && (x_cur == '0) && (y_q == '0);
         tlast_q      <= pix_keep && (x_cur == width_q - X_ONE);
         frame_done_q <= frame_end;
         size_err_q   <= size_err_d;
         overflow_q   <= overflow_q | (tvalid_q & ~m_axis_tready);
      end
   end

   assign m_axis_tvalid  = tvalid_q;
   assign m_axis_tdata   = tdata_q;
   assign m_axis_tuser   = tuser_q;
   assign m_axis_tlast   = tlast_q;
   assign sts_busy       = (state_q != ST_IDLE);
   assign sts_frame_done = frame_done_q;
   assign sts_size_err   = size_err_q;
   assign sts_overflow   = overflow_q;

`ifdef CMOS_CAPTURE_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

   // Saturating frame and size-error counters.
   always_ff @(posedge cmos_pclk) begin
      if (cmos_rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         if (frame_end)  frame_cnt_q <= sat_inc_cnt(frame_cnt_q);
         if (size_err_d) err_cnt_q   <= sat_inc_cnt(err_cnt_q);
      end
   end

   assign sts_frame_cnt = frame_cnt_q;
   assign sts_err_cnt   = err_cnt_q;
`else
   assign sts_frame_cnt = '0;
   assign sts_err_cnt   = '0;
`endif

endmodule
